// File: rtl/xoperand_entry.sv
// Keypad-driven signed decimal operand entry with iterative backspace (divide by 10)
// and a one-cycle load strobe into a downstream register.
`ifndef DATA_W
`define DATA_W 32
`endif

module xoperand_entry #(
  parameter int unsigned N          = `DATA_W,
  parameter int unsigned MAX_DIGITS = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic         key_ready,
  output logic [N-1:0] value,
  output logic [3:0]   digits,
  output logic         load,
  output logic         overflow
);

  localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StDiv, StLoad} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    mag_q, mag_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [3:0]      rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [3:0]      dig_q, dig_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic [N+3:0]    mac;
  logic [4:0]      rem_shift;
  logic            rem_ge;
  logic [N-1:0]    quo_next;

  assign key_ready = (state_q == StIdle) && !rst;
  assign load      = (state_q == StLoad) && !rst;
  assign accept    = key_valid && key_ready;
  assign value     = sign_q ? (~mag_q + 1'b1) : mag_q;
  assign digits    = dig_q;
  assign overflow  = ovf_q;

  // magnitude*10 + digit, kept N+4 bits wide before truncation
  assign mac = ({4'b0, mag_q} << 3) + ({4'b0, mag_q} << 1) + {{N{1'b0}}, key_code};

  // One restoring-division step: quotient bits shift in while the dividend shifts out
  assign rem_shift = {rem_q, quo_q[N-1]};
  assign rem_ge    = (rem_shift >= 5'd10);
  assign quo_next  = {quo_q[N-2:0], rem_ge};

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (key_code <= 4'd9) begin
            if (key_code == 4'd0 && mag_q == '0) begin
              mag_d = mag_q;
            end else if (dig_q == 4'(MAX_DIGITS)) begin
              ovf_d = 1'b1;
            end else begin
              mag_d = mac[N-1:0];
              dig_d = dig_q + 4'd1;
            end
          end else begin
            case (key_code)
              4'd10: if (mag_q != '0) sign_d = ~sign_q;
              4'd11: begin
                if (dig_q != 4'd0) begin
                  state_d = StDiv;
                  quo_d   = mag_q;
                  rem_d   = 4'd0;
                  cnt_d   = '0;
                end
              end
              4'd12: begin
                mag_d  = '0;
                sign_d = 1'b0;
                dig_d  = 4'd0;
                ovf_d  = 1'b0;
              end
              4'd13:   state_d = StLoad;
              default: state_d = StIdle;
            endcase
          end
        end
      end
      StDiv: begin
        quo_d = quo_next;
        rem_d = rem_ge ? 4'(rem_shift - 5'd10) : rem_shift[3:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StIdle;
          mag_d   = quo_next;
          dig_d   = dig_q - 4'd1;
          if (quo_next == '0) sign_d = 1'b0;
        end
      end
      StLoad: begin
        state_d = StIdle;
        mag_d   = '0;
        sign_d  = 1'b0;
        dig_d   = 4'd0;
        ovf_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mag_q   <= '0;
      quo_q   <= '0;
      rem_q   <= 4'd0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dig_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_xoperand_entry.sv
// Directed bench for xoperand_entry: table of key/expected-output records plus
// hand-written sequences for backspace timing, overflow and reset corner cases.
module tb_xoperand_entry;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [31:0] value;
  logic [3:0]  digits;
  logic        load;
  logic        overflow;

  int checks;
  int failures;

  xoperand_entry #(.N(32), .MAX_DIGITS(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .value     (value),
    .digits    (digits),
    .load      (load),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] val;
    logic [3:0]  dig;
    logic        ovf;
    logic        ld;
    logic        rdy;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one key at a negedge, let it transfer, return at the following negedge.
  task automatic send_key(input logic [3:0] c);
    int t;
    t = 0;
    while (!key_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!key_ready) begin
      checks++;
      failures++;
      $display("FAIL key_ready_timeout actual=0 required=1");
    end
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic wait_div(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (!key_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk(name, 32'(cnt), 32'(exp_cycles));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;

    //              code    value          dig   ovf  ld   rdy
    vecs[0]  = '{4'd1,  32'd1,         4'd1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4'd2,  32'd12,        4'd2, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'd3,  32'd123,       4'd3, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{4'd13, 32'd123,       4'd3, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd4,  32'd4,         4'd1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'd5,  32'd45,        4'd2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{4'd10, 32'hFFFF_FFD3, 4'd2, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'd13, 32'hFFFF_FFD3, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'd0,  32'd0,         4'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'd0,  32'd0,         4'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'd7,  32'd7,         4'd1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd10, 32'hFFFF_FFF9, 4'd1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{4'd14, 32'hFFFF_FFF9, 4'd1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{4'd12, 32'd0,         4'd0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{4'd10, 32'd0,         4'd0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{4'd15, 32'd0,         4'd0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{4'd11, 32'd0,         4'd0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(key_ready), 32'd0);
    chk("load_in_reset", 32'(load), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(key_ready), 32'd1);
    chk("value_after_reset", value, 32'd0);
    chk("digits_after_reset", 32'(digits), 32'd0);
    chk("ovf_after_reset", 32'(overflow), 32'd0);

    // Table-driven key sequence
    for (int i = 0; i < 17; i++) begin
      send_key(vecs[i].code);
      chk($sformatf("v%0d_value", i), value, vecs[i].val);
      chk($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].dig));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_load", i), 32'(load), 32'(vecs[i].ld));
      chk($sformatf("v%0d_ready", i), 32'(key_ready), 32'(vecs[i].rdy));
      if (vecs[i].code == 4'd13) begin
        @(negedge clk);
        chk($sformatf("v%0d_post_value", i), value, 32'd0);
        chk($sformatf("v%0d_post_digits", i), 32'(digits), 32'd0);
        chk($sformatf("v%0d_post_load", i), 32'(load), 32'd0);
      end
    end

    // Backspace: 987 -> 98 after exactly 32 busy cycles
    send_key(4'd9);
    send_key(4'd8);
    send_key(4'd7);
    send_key(4'd11);
    chk("bs_value_held", value, 32'd987);
    wait_div("bs_busy_cycles", 32);
    chk("bs_value", value, 32'd98);
    chk("bs_digits", 32'(digits), 32'd2);
    chk("bs_ready", 32'(key_ready), 32'd1);

    // Backspace to zero clears the sign
    send_key(4'd12);
    send_key(4'd5);
    send_key(4'd10);
    chk("neg5_value", value, 32'hFFFF_FFFB);
    send_key(4'd11);
    wait_div("bs0_busy_cycles", 32);
    chk("bs0_value", value, 32'd0);
    chk("bs0_digits", 32'(digits), 32'd0);
    send_key(4'd3);
    chk("sign_cleared_value", value, 32'd3);

    // Capacity overflow, sticky through backspace, cleared by CLEAR
    send_key(4'd12);
    for (int k = 0; k < 10; k++) send_key(4'd9);
    chk("ovf_value", value, 32'd999999999);
    chk("ovf_digits", 32'(digits), 32'd9);
    chk("ovf_flag", 32'(overflow), 32'd1);
    send_key(4'd11);
    wait_div("ovf_bs_cycles", 32);
    chk("ovf_bs_value", value, 32'd99999999);
    chk("ovf_bs_digits", 32'(digits), 32'd8);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    send_key(4'd12);
    chk("clear_value", value, 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Reset five cycles into DIV
    send_key(4'd6);
    send_key(4'd11);
    repeat (4) @(negedge clk);
    chk("mid_div_ready", 32'(key_ready), 32'd0);
    chk("mid_div_value", value, 32'd6);
    rst = 1'b1;
    @(negedge clk);
    chk("div_rst_value", value, 32'd0);
    chk("div_rst_digits", 32'(digits), 32'd0);
    chk("div_rst_load", 32'(load), 32'd0);
    chk("div_rst_ready", 32'(key_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("div_rst_ready_after", 32'(key_ready), 32'd1);

    // Reset while in LOAD forces load low
    send_key(4'd2);
    send_key(4'd13);
    chk("load_before_rst", 32'(load), 32'd1);
    rst = 1'b1;
    #1;
    chk("load_forced_low", 32'(load), 32'd0);
    @(negedge clk);
    chk("load_rst_value", value, 32'd0);
    chk("load_rst_load", 32'(load), 32'd0);
    rst = 1'b0;
    #1;
    chk("load_rst_ready", 32'(key_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xoperand_entry.md
XOPERAND_ENTRY -- requirements
Module: xoperand_entry

Interface
REQ-001 Parameter N, default `DATA_W, operand width in bits (two's complement).
REQ-002 Parameter MAX_DIGITS, default 9, maximum decimal digits held; SHALL satisfy 10^MAX_DIGITS-1 < 2^(N-1).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_valid  input  1  keypad code available.
REQ-006 key_code  input  4  0-9 digit, 10 NEG, 11 BACKSPACE, 12 CLEAR, 13 ENTER, 14-15 reserved.
REQ-007 key_ready  output  1  block can accept a key this cycle.
REQ-008 value  output  N  signed operand under entry; drives downstream register D.
REQ-009 digits  output  4  count of significant digits entered.
REQ-010 load  output  1  one-cycle strobe; drives downstream register enable.
REQ-011 overflow  output  1  sticky flag, digit rejected for capacity.

Function
REQ-012 Key transferred only on posedge where key_valid=1 and key_ready=1; upstream holds key_valid/key_code stable until transfer; no key lost or duplicated.
REQ-013 Internal state: magnitude (N bits, unsigned), sign (1 bit), digit count, FSM {IDLE, DIV, LOAD}.
REQ-014 key_ready=1 only in IDLE and not in reset.
REQ-015 value = sign ? -magnitude : magnitude, combinational from registered state.
REQ-016 Digit d in IDLE: if digits<MAX_DIGITS, magnitude <= magnitude*10+d (computed N+4 bits, truncated to N), next cycle.
REQ-017 Leading zero: digit 0 while magnitude==0 accepted, no state change, digits stays 0.
REQ-018 Digit when digits==MAX_DIGITS: accepted (consumed), magnitude unchanged, overflow <= 1.
REQ-019 NEG: sign toggles if magnitude!=0; ignored (consumed) if magnitude==0.
REQ-020 BACKSPACE with digits==0: consumed, ignored, stays IDLE.
REQ-021 BACKSPACE with digits>0: go to DIV; iterative restoring divide of magnitude by 10, exactly N cycles in DIV, key_ready=0 throughout.
REQ-022 DIV exit: magnitude <= floor(magnitude/10), digits <= digits-1, sign <= 0 if quotient==0, return IDLE.
REQ-023 CLEAR: magnitude, sign, digits, overflow <= 0 next cycle; stays IDLE.
REQ-024 ENTER: go to LOAD; in LOAD load=1 for exactly one cycle, value held at entered operand.
REQ-025 LOAD exit: magnitude, sign, digits, overflow <= 0, return IDLE; LOAD lasts one cycle.
REQ-026 Reserved codes 14-15: consumed, no effect.
REQ-027 load=0 in all states except LOAD.
REQ-028 overflow clears only on CLEAR, LOAD exit, reset.

Reset
REQ-029 rst=1 at posedge: state IDLE, magnitude 0, sign 0, digits 0, overflow 0, load 0; value reads 0.
REQ-030 rst has priority over every key and every state, including mid-DIV and in LOAD (load forced 0 that cycle onward).
REQ-031 key_ready=0 while rst=1; =1 the first cycle after rst deasserts.

Verification
REQ-032 Keys 1,2,3,ENTER -> load=1 one cycle with value=123; next cycle value=0, digits=0.
REQ-033 Keys 4,5,NEG,ENTER (N=32) -> load pulse with value=0xFFFFFFD3 (-45).
REQ-034 Keys 9,8,7,BACKSPACE (N=32) -> key_ready=0 for 32 cycles, then value=98, digits=2, key_ready=1.
REQ-035 Ten '9' keys, MAX_DIGITS=9 -> value=999999999, digits=9, overflow=1; CLEAR -> value=0, overflow=0.
REQ-036 Keys 0,0,7 -> digits=1, value=7; BACKSPACE at digits=0 -> no DIV, key_ready stays 1.
REQ-037 rst asserted 5 cycles into DIV -> following cycle value=0, digits=0, load=0; key_ready=1 after rst drops.
